pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_ADDR, default 8'h80, PC value loaded by reset.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles mem_req may wait for mem_ack; legal range 1-255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  begin fetching at init_addr (sampled in IDLE, HALT, ERR).
REQ-006 init_addr  in  8  start address.
REQ-007 jump_en / jump_addr  in  1 / 8  absolute redirect.
REQ-008 branch_en / branch_off  in  1 / 8  relative redirect, two's-complement offset.
REQ-009 stall  in  1  hold in NEXT.
REQ-010 halt  in  1  stop after the current fetch.
REQ-011 mem_ack  in  1  memory accepted the request.
REQ-012 mem_req  out  1  fetch request.
REQ-013 mem_addr  out  8  fetch address; equals pc_addr while mem_req=1.
REQ-014 pc_addr  out  8  current PC register.
REQ-015 fetch_done  out  1  one-cycle pulse per completed fetch.
REQ-016 busy  out  1  high in FETCH and NEXT.
REQ-017 err  out  1  timeout flag.
REQ-018 fetch_cnt  out  16  completed-fetch counter, saturating at 16'hFFFF.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, NEXT, HALT, ERR.
REQ-020 IDLE/HALT/ERR: start=1 -> pc_addr<=init_addr, err<=0, wait counter<=0, go FETCH next cycle.
REQ-021 FETCH: mem_req=1 combinationally, mem_addr=pc_addr; on mem_ack=1 -> fetch_done=1 the following cycle, fetch_cnt+1, go NEXT.
REQ-022 FETCH without mem_ack: wait counter +1 per cycle; when counter reaches TIMEOUT without ack -> go ERR, err<=1, mem_req drops on that transition.
REQ-023 mem_ack arriving on the same cycle the counter reaches TIMEOUT SHALL count as success, not an error.
REQ-024 mem_ack outside FETCH SHALL be ignored.
REQ-025 NEXT: stall=1 -> remain in NEXT, pc_addr unchanged, no redirect evaluated.
REQ-026 NEXT, stall=0: halt=1 -> go HALT, pc_addr unchanged; otherwise update PC and go FETCH.
REQ-027 PC update priority: jump_en -> jump_addr; else branch_en -> pc_addr + sign-extended branch_off; else pc_addr + 1.
REQ-028 PC arithmetic SHALL be modulo 256 (8'hFF+1 = 8'h00; 8'h02 + 8'hFC = 8'hFE).
REQ-029 Minimum fetch period: 2 cycles (FETCH with immediate ack, NEXT).
REQ-030 busy=1 exactly in FETCH and NEXT; err stays 1 until start or rst.
REQ-031 start while busy=1 SHALL be ignored.

Reset
REQ-032 rst=1 SHALL immediately force: state IDLE, pc_addr=RESET_ADDR, mem_req=0, fetch_done=0, busy=0, err=0, fetch_cnt=0, wait counter=0.
REQ-033 Reset asserted mid-FETCH SHALL drop mem_req without waiting for a clock edge; an ack arriving during reset SHALL have no effect.
REQ-034 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-035 Reset then start with init_addr=8'h80, mem_ack tied 1 -> mem_addr sequence 80,81,82 on successive FETCH cycles, fetch_done every 2nd cycle, fetch_cnt=3 after three fetches.
REQ-036 PC at 8'hFF, no redirect -> next fetch address 8'h00.
REQ-037 In NEXT at pc 8'h10, jump_en=1 (jump_addr=8'h40) and branch_en=1 (off=8'hF0) together -> next fetch at 8'h40; branch alone -> 8'h00.
REQ-038 stall held 3 cycles in NEXT -> pc_addr and fetch_cnt unchanged, mem_req=0 for those cycles, fetch resumes the cycle after stall drops.
REQ-039 TIMEOUT=4, mem_ack held 0 -> err=1 after 4 FETCH cycles, state ERR, mem_req=0; then start -> err=0, FETCH at init_addr.
REQ-040 rst pulsed between clock edges during FETCH -> mem_req, busy fall immediately; pc_addr=8'h80, fetch_cnt=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller.
// Walks the PC through memory one request at a time, applying jump/branch
// redirects between fetches, with stall/halt control and an ack timeout.
module pc_fetch_ctrl #(
   parameter logic [7:0]  RESET_ADDR = 8'h80,
   parameter int unsigned TIMEOUT    = 15     // 1..255 cycles allowed per request
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  init_addr,
   input  logic        jump_en,
   input  logic [7:0]  jump_addr,
   input  logic        branch_en,
   input  logic [7:0]  branch_off,
   input  logic        stall,
   input  logic        halt,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic [7:0]  mem_addr,
   output logic [7:0]  pc_addr,
   output logic        fetch_done,
   output logic        busy,
   output logic        err,
   output logic [15:0] fetch_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      NEXT  = 3'd2,
      HALT  = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Last wait-count value that may still see an ack; an ack on that cycle wins.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic [7:0] pc_nxt;

   // Request and busy decode straight from the state register so an async
   // reset pulls them low without waiting for a clock edge.
   assign mem_req  = (state == FETCH);
   assign busy     = (state == FETCH) || (state == NEXT);
   assign mem_addr = pc_addr;

   // Redirect selection: jump beats branch beats sequential. An 8-bit add of
   // the offset is the same as adding its sign extension modulo 256.
   always_comb begin
      pc_nxt = pc_addr + 8'd1;
      if (jump_en)
         pc_nxt = jump_addr;
      else if (branch_en)
         pc_nxt = pc_addr + branch_off;
   end

   // Fetch FSM with registered PC, completion pulse, counter and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc_addr    <= RESET_ADDR;
         wait_cnt   <= 8'd0;
         fetch_done <= 1'b0;
         err        <= 1'b0;
         fetch_cnt  <= 16'd0;
      end else begin
         fetch_done <= 1'b0;
         case (state)
            IDLE, HALT, ERR: begin
               if (start) begin
                  pc_addr  <= init_addr;
                  err      <= 1'b0;
                  wait_cnt <= 8'd0;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  fetch_done <= 1'b1;
                  if (fetch_cnt != 16'hFFFF)
                     fetch_cnt <= fetch_cnt + 16'd1;
                  state <= NEXT;
               end else if (wait_cnt == WAIT_LAST) begin
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            NEXT: begin
               // A stalled NEXT holds everything and ignores redirects.
               if (!stall) begin
                  if (halt) begin
                     state <= HALT;
                  end else begin
                     pc_addr  <= pc_nxt;
                     wait_cnt <= 8'd0;
                     state    <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_pc_fetch_ctrl;

   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  init_addr;
   logic        jump_en;
   logic [7:0]  jump_addr;
   logic        branch_en;
   logic [7:0]  branch_off;
   logic        stall;
   logic        halt;
   logic        mem_ack;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic [7:0]  pc_addr;
   logic        fetch_done;
   logic        busy;
   logic        err;
   logic [15:0] fetch_cnt;

   pc_fetch_ctrl #(.RESET_ADDR(8'h80), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .init_addr(init_addr),
      .jump_en(jump_en), .jump_addr(jump_addr),
      .branch_en(branch_en), .branch_off(branch_off),
      .stall(stall), .halt(halt), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_addr(mem_addr), .pc_addr(pc_addr),
      .fetch_done(fetch_done), .busy(busy), .err(err), .fetch_cnt(fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Behavioural model: mode names from the state list, plain integer PC math.
   localparam int M_IDLE = 0, M_FETCH = 1, M_NEXT = 2, M_HALT = 3, M_ERR = 4;
   int m_st, m_pc, m_cnt, m_wait;
   bit m_err, m_done;

   task automatic model_reset();
      m_st = M_IDLE; m_pc = 'h80; m_cnt = 0; m_wait = 0; m_err = 0; m_done = 0;
   endtask

   task automatic model_edge();
      if (rst) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (m_st == M_IDLE || m_st == M_HALT || m_st == M_ERR) begin
         if (start) begin
            m_pc = int'(init_addr); m_err = 0; m_wait = 0; m_st = M_FETCH;
         end
      end else if (m_st == M_FETCH) begin
         if (mem_ack) begin
            m_done = 1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            m_st = M_NEXT;
         end else begin
            m_wait = m_wait + 1;
            if (m_wait >= TO) begin m_st = M_ERR; m_err = 1; end
         end
      end else if (m_st == M_NEXT) begin
         if (!stall) begin
            if (halt) m_st = M_HALT;
            else begin
               if (jump_en)        m_pc = int'(jump_addr);
               else if (branch_en) m_pc = (m_pc + int'($signed(branch_off))) & 255;
               else                m_pc = (m_pc + 1) % 256;
               m_wait = 0;
               m_st = M_FETCH;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ":pc"},   32'(pc_addr),    32'(m_pc));
      chk({tag, ":req"},  32'(mem_req),    32'(m_st == M_FETCH));
      chk({tag, ":busy"}, 32'(busy),       32'(m_st == M_FETCH || m_st == M_NEXT));
      chk({tag, ":done"}, 32'(fetch_done), 32'(m_done));
      chk({tag, ":err"},  32'(err),        32'(m_err));
      chk({tag, ":cnt"},  32'(fetch_cnt),  32'(m_cnt));
      if (m_st == M_FETCH) chk({tag, ":addr"}, 32'(mem_addr), 32'(m_pc));
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic go_halt();
      halt = 1'b1;
      repeat (3) step("halt");
      halt = 1'b0;
      chk("halted_busy", 32'(busy), 32'd0);
   endtask

   task automatic launch(input logic [7:0] a);
      init_addr = a; start = 1'b1;
      step("start");
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; init_addr = 8'h00; jump_en = 1'b0; jump_addr = 8'h00;
      branch_en = 1'b0; branch_off = 8'h00; stall = 1'b0; halt = 1'b0; mem_ack = 1'b0;
      model_reset();

      // Reset state; ack during reset has no effect.
      step("rst"); step("rst");
      mem_ack = 1'b1;
      step("rst_ack");
      rst = 1'b0; mem_ack = 1'b0;
      repeat (3) step("idle");

      // Sequential fetches 80,81,82 with ack tied high.
      mem_ack = 1'b1;
      launch(8'h80);
      chk("seq_a0", 32'(mem_addr), 32'h80);
      step("seq"); step("seq");
      chk("seq_a1", 32'(mem_addr), 32'h81);
      step("seq"); step("seq");
      chk("seq_a2", 32'(mem_addr), 32'h82);
      step("seq");
      chk("cnt3", 32'(fetch_cnt), 32'd3);
      chk("done_pulse", 32'(fetch_done), 32'd1);
      go_halt();

      // PC wraps 8'hFF -> 8'h00.
      launch(8'hFF);
      step("wrap"); step("wrap");
      chk("wrap_addr", 32'(mem_addr), 32'h00);
      go_halt();

      // Jump has priority over branch.
      launch(8'h10);
      step("pri");
      jump_en = 1'b1; jump_addr = 8'h40; branch_en = 1'b1; branch_off = 8'hF0;
      step("pri");
      chk("jump_pri", 32'(mem_addr), 32'h40);
      jump_en = 1'b0; branch_en = 1'b0;
      go_halt();

      // Branch alone: 8'h10 + (-16) = 8'h00.
      launch(8'h10);
      step("br");
      branch_en = 1'b1; branch_off = 8'hF0;
      step("br");
      chk("branch_addr", 32'(mem_addr), 32'h00);
      branch_en = 1'b0;

      // Stall held three cycles in NEXT.
      step("to_next");
      stall = 1'b1;
      repeat (3) begin
         step("stall");
         chk("stall_req", 32'(mem_req), 32'd0);
      end
      stall = 1'b0;
      step("resume");
      chk("resume_req", 32'(mem_req), 32'd1);
      chk("resume_addr", 32'(mem_addr), 32'h01);

      // Timeout after TO fetch cycles without ack.
      mem_ack = 1'b0;
      repeat (TO - 1) step("wait");
      chk("pre_timeout_err", 32'(err), 32'd0);
      step("timeout");
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_req", 32'(mem_req), 32'd0);
      step("err_hold");
      launch(8'h20);
      chk("restart_err", 32'(err), 32'd0);
      chk("restart_addr", 32'(mem_addr), 32'h20);

      // Ack on the last allowed cycle counts as success.
      repeat (TO - 1) step("late");
      mem_ack = 1'b1;
      step("late_ack");
      chk("late_ack_err", 32'(err), 32'd0);
      chk("late_ack_done", 32'(fetch_done), 32'd1);

      // Async reset between edges while fetching.
      step("pre_rst");
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      chk("async_req", 32'(mem_req), 32'd0);
      chk("async_pc", 32'(pc_addr), 32'h80);
      step("rst_hold");
      rst = 1'b0;
      step("post_rst");

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 79) == 0);
         start      = ($urandom_range(0, 3) == 0);
         init_addr  = 8'($urandom_range(0, 255));
         jump_en    = ($urandom_range(0, 5) == 0);
         jump_addr  = 8'($urandom_range(0, 255));
         branch_en  = ($urandom_range(0, 3) == 0);
         branch_off = 8'($urandom_range(0, 255));
         stall      = ($urandom_range(0, 3) == 0);
         halt       = ($urandom_range(0, 9) == 0);
         mem_ack    = ($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
